// File: rtl/gpio_serial_loader_if.sv
// gpio_serial_loader_if: bus between the pad-configuration loader, the
// housekeeping register bank (cfg_addr/cfg_word) and the pad control chain.
interface gpio_serial_loader_if #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13
);
  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  logic                start;
  logic [AW-1:0]       cfg_addr;
  logic [CFG_BITS-1:0] cfg_word;
  logic                serial_clock;
  logic                serial_data;
  logic                serial_load;
  logic                busy;
  logic                done;

  // Loader side: requests words by address and drives the serial chain.
  modport master (
    input  start, cfg_word,
    output cfg_addr, serial_clock, serial_data, serial_load, busy, done
  );

  // Environment side: register bank, requester and chain.
  modport slave (
    output start, cfg_word,
    input  cfg_addr, serial_clock, serial_data, serial_load, busy, done
  );
endinterface

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: fetches one configuration word per user pad and shifts
// the whole set, highest pad first and MSB first, into the daisy-chained pad
// control blocks, then pulses a parallel load strobe. All outputs registered.
module gpio_serial_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input logic                  clock,
  input logic                  reset,
  gpio_serial_loader_if.master bus
);
  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [AW-1:0]       addr_r, addr_s;
  logic [CFG_BITS-1:0] shreg_r, shreg_s, shifted_s;
  logic [BW-1:0]       bit_r, bit_s;
  logic [DW-1:0]       div_r, div_s;
  logic                phase_r, phase_s;   // 0: serial_clock low half, 1: high half
  logic                sclk_r, sclk_s;
  logic                sdata_r, sdata_s;
  logic                sload_r, sload_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                div_end_s, bit_end_s, word_end_s;

  assign shifted_s  = shreg_r << 1'b1;
  assign div_end_s  = (div_r == LAST_DIV);
  assign bit_end_s  = (bit_r == LAST_BIT);
  // Last divider cycle of the high half of the last bit of the current word.
  assign word_end_s = phase_r & div_end_s & bit_end_s;

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        state_s = SHIFT;
      end
      SHIFT: begin
        if (word_end_s) begin
          if (addr_r != {AW{1'b0}}) begin
            state_s = FETCH;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      LOAD: begin
        if (div_end_s) begin
          state_s = IDLE;
        end else begin
          state_s = LOAD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    addr_s  = addr_r;
    shreg_s = shreg_r;
    bit_s   = bit_r;
    div_s   = div_r;
    phase_s = phase_r;
    sclk_s  = 1'b0;
    sdata_s = sdata_r;
    sload_s = 1'b0;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          addr_s = LAST_PAD;
          busy_s = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      FETCH: begin
        shreg_s = bus.cfg_word;
        sdata_s = bus.cfg_word[CFG_BITS-1];
        bit_s   = {BW{1'b0}};
        div_s   = {DW{1'b0}};
        phase_s = 1'b0;
      end
      SHIFT: begin
        sclk_s = phase_r;
        if (!div_end_s) begin
          div_s = div_r + DW'(1);
        end else if (!phase_r) begin
          // End of the low half: raise the chain clock.
          div_s   = {DW{1'b0}};
          phase_s = 1'b1;
          sclk_s  = 1'b1;
        end else begin
          // End of the high half: drop the clock and present the next bit.
          div_s   = {DW{1'b0}};
          phase_s = 1'b0;
          sclk_s  = 1'b0;
          shreg_s = shifted_s;
          if (!bit_end_s) begin
            bit_s   = bit_r + BW'(1);
            sdata_s = shifted_s[CFG_BITS-1];
          end else if (addr_r != {AW{1'b0}}) begin
            addr_s = addr_r - AW'(1);
          end else begin
            sload_s = 1'b1;
          end
        end
      end
      LOAD: begin
        if (div_end_s) begin
          div_s  = {DW{1'b0}};
          busy_s = 1'b0;
          done_s = 1'b1;
        end else begin
          div_s   = div_r + DW'(1);
          sload_s = 1'b1;
        end
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_r  <= {AW{1'b0}};
      shreg_r <= {CFG_BITS{1'b0}};
      bit_r   <= {BW{1'b0}};
      div_r   <= {DW{1'b0}};
      phase_r <= 1'b0;
      sclk_r  <= 1'b0;
      sdata_r <= 1'b0;
      sload_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      addr_r  <= addr_s;
      shreg_r <= shreg_s;
      bit_r   <= bit_s;
      div_r   <= div_s;
      phase_r <= phase_s;
      sclk_r  <= sclk_s;
      sdata_r <= sdata_s;
      sload_r <= sload_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.cfg_addr     = addr_r;
  assign bus.serial_clock = sclk_r;
  assign bus.serial_data  = sdata_r;
  assign bus.serial_load  = sload_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader: scoreboard bench for the pad configuration loader.
// Three instances: a small chain (3x4, div 1), the default chain (38x13,
// div 2) and a slow chain (4x5, div 3) used for data-stability checks.
`timescale 1ns/1ps
module tb_gpio_serial_loader;
  localparam int A_PADS = 3,  A_BITS = 4,  A_DIV = 1;
  localparam int B_PADS = 38, B_BITS = 13, B_DIV = 2;
  localparam int C_PADS = 4,  C_BITS = 5,  C_DIV = 3;
  localparam int A_BUSY = A_PADS * (1 + 2 * A_DIV * A_BITS) + A_DIV;  // 28
  localparam int B_BUSY = B_PADS * (1 + 2 * B_DIV * B_BITS) + B_DIV;  // 2016
  localparam int C_BUSY = C_PADS * (1 + 2 * C_DIV * C_BITS) + C_DIV;  // 127

  logic clock = 1'b0;
  logic reset_a;
  logic reset_bc;
  always #5 clock = ~clock;

  gpio_serial_loader_if #(.NUM_PADS(A_PADS), .CFG_BITS(A_BITS)) bus_a ();
  gpio_serial_loader_if #(.NUM_PADS(B_PADS), .CFG_BITS(B_BITS)) bus_b ();
  gpio_serial_loader_if #(.NUM_PADS(C_PADS), .CFG_BITS(C_BITS)) bus_c ();

  logic [A_BITS-1:0] mem_a [0:3];
  logic [B_BITS-1:0] mem_b [0:63];
  logic [C_BITS-1:0] mem_c [0:3];
  assign bus_a.cfg_word = mem_a[bus_a.cfg_addr];
  assign bus_b.cfg_word = mem_b[bus_b.cfg_addr];
  assign bus_c.cfg_word = mem_c[bus_c.cfg_addr];

  gpio_serial_loader #(.NUM_PADS(A_PADS), .CFG_BITS(A_BITS), .CLK_DIV(A_DIV)) dut_a (
    .clock(clock), .reset(reset_a), .bus(bus_a.master));
  gpio_serial_loader #(.NUM_PADS(B_PADS), .CFG_BITS(B_BITS), .CLK_DIV(B_DIV)) dut_b (
    .clock(clock), .reset(reset_bc), .bus(bus_b.master));
  gpio_serial_loader #(.NUM_PADS(C_PADS), .CFG_BITS(C_BITS), .CLK_DIV(C_DIV)) dut_c (
    .clock(clock), .reset(reset_bc), .bus(bus_c.master));

  int total = 0;
  int bad = 0;

  logic exp_a [$];
  logic exp_b [$];
  logic exp_c [$];
  int busy_width_a = 0, load_width_a = 0, load_cnt_a = 0, done_cnt_a = 0, xfer_cnt_a = 0;
  int busy_width_b = 0, rises_b = 0;
  int busy_width_c = 0;
  logic [B_BITS-1:0] rec_b [$];
  logic [5:0] addr_log_b [$];

  // Expected stream: highest pad first, each word MSB first.
  task automatic push_a();
    for (int p = A_PADS - 1; p >= 0; p--)
      for (int b = A_BITS - 1; b >= 0; b--) exp_a.push_back(mem_a[p][b]);
  endtask

  task automatic push_b();
    for (int p = B_PADS - 1; p >= 0; p--)
      for (int b = B_BITS - 1; b >= 0; b--) exp_b.push_back(mem_b[p][b]);
  endtask

  task automatic push_c();
    for (int p = C_PADS - 1; p >= 0; p--)
      for (int b = C_BITS - 1; b >= 0; b--) exp_c.push_back(mem_c[p][b]);
  endtask

  task automatic wait_done(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if ((which == 0 && bus_a.done === 1'b1) || (which == 1 && bus_b.done === 1'b1) ||
          (which == 2 && bus_c.done === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Chain A observer: pops the scoreboard on every serial_clock rise.
  task automatic monitor_a();
    logic ps = 1'b0, pb = 1'b0, pd = 1'b0, pl = 1'b0;
    logic eb;
    int busy_run = 0;
    int load_run = 0;
    forever begin
      @(negedge clock);
      if (bus_a.serial_clock === 1'b1 && ps === 1'b0) begin
        total++;
        if (exp_a.size() == 0) begin
          bad++;
          $display("FAIL a_bit: got unexpected bit %0b, required no bit", bus_a.serial_data);
        end else begin
          eb = exp_a.pop_front();
          if (bus_a.serial_data !== eb) begin
            bad++;
            $display("FAIL a_bit: got %0b, required %0b", bus_a.serial_data, eb);
          end
        end
      end
      if (bus_a.serial_load === 1'b1) begin
        total++;
        if (bus_a.serial_clock !== 1'b0) begin
          bad++;
          $display("FAIL a_overlap: got serial_clock=%0b during load, required 0", bus_a.serial_clock);
        end
      end
      if (pb === 1'b1 && bus_a.busy === 1'b0 && reset_a === 1'b0) begin
        busy_width_a = busy_run;
        total++;
        if (bus_a.done !== 1'b1) begin
          bad++;
          $display("FAIL a_done_after_busy: got done=%0b, required 1", bus_a.done);
        end
      end
      if (pd === 1'b1) begin
        total++;
        if (bus_a.done !== 1'b0) begin
          bad++;
          $display("FAIL a_done_width: got done=%0b two cycles running, required 0", bus_a.done);
        end
      end
      busy_run = (bus_a.busy === 1'b1) ? busy_run + 1 : 0;
      if (bus_a.busy === 1'b1 && pb !== 1'b1) xfer_cnt_a++;
      if (bus_a.serial_load === 1'b1) load_run++;
      else if (load_run != 0) begin
        load_width_a = load_run;
        load_run = 0;
      end
      if (bus_a.serial_load === 1'b1 && pl !== 1'b1) load_cnt_a++;
      if (bus_a.done === 1'b1) done_cnt_a++;
      ps = bus_a.serial_clock; pb = bus_a.busy; pd = bus_a.done; pl = bus_a.serial_load;
    end
  endtask

  // Chain B observer: scoreboard, rise count, recovered words, address log.
  task automatic monitor_b();
    logic ps = 1'b0, pb = 1'b0;
    logic [5:0] pa = 6'd0;
    logic eb;
    logic [B_BITS-1:0] acc = '0;
    int nbits = 0;
    int busy_run = 0;
    forever begin
      @(negedge clock);
      if (bus_b.serial_clock === 1'b1 && ps === 1'b0) begin
        rises_b++;
        acc = {acc[B_BITS-2:0], bus_b.serial_data};
        nbits++;
        if (nbits == B_BITS) begin
          rec_b.push_back(acc);
          nbits = 0;
        end
        total++;
        if (exp_b.size() == 0) begin
          bad++;
          $display("FAIL b_bit: got unexpected bit %0b, required no bit", bus_b.serial_data);
        end else begin
          eb = exp_b.pop_front();
          if (bus_b.serial_data !== eb) begin
            bad++;
            $display("FAIL b_bit: got %0b, required %0b", bus_b.serial_data, eb);
          end
        end
      end
      if (bus_b.busy === 1'b1 && (pb !== 1'b1 || bus_b.cfg_addr !== pa))
        addr_log_b.push_back(bus_b.cfg_addr);
      if (pb === 1'b1 && bus_b.busy === 1'b0) busy_width_b = busy_run;
      busy_run = (bus_b.busy === 1'b1) ? busy_run + 1 : 0;
      ps = bus_b.serial_clock; pb = bus_b.busy; pa = bus_b.cfg_addr;
    end
  endtask

  // Chain C observer: scoreboard plus data setup/hold and strobe separation.
  task automatic monitor_c();
    logic ps = 1'b0, pb = 1'b0, pdat = 1'b0;
    logic eb;
    int stable = 0;
    int busy_run = 0;
    forever begin
      @(negedge clock);
      stable = (bus_c.serial_data === pdat) ? stable + 1 : 0;
      if (bus_c.serial_clock === 1'b1 && ps === 1'b0) begin
        total++;
        if (stable < C_DIV) begin
          bad++;
          $display("FAIL c_setup: got %0d stable cycles before rise, required >= %0d", stable, C_DIV);
        end
        total++;
        if (exp_c.size() == 0) begin
          bad++;
          $display("FAIL c_bit: got unexpected bit %0b, required no bit", bus_c.serial_data);
        end else begin
          eb = exp_c.pop_front();
          if (bus_c.serial_data !== eb) begin
            bad++;
            $display("FAIL c_bit: got %0b, required %0b", bus_c.serial_data, eb);
          end
        end
      end
      if (bus_c.serial_clock === 1'b1 && ps === 1'b1) begin
        total++;
        if (bus_c.serial_data !== pdat) begin
          bad++;
          $display("FAIL c_hold: got data %0b while clock high, required %0b", bus_c.serial_data, pdat);
        end
      end
      if (bus_c.serial_load === 1'b1) begin
        total++;
        if (bus_c.serial_clock !== 1'b0) begin
          bad++;
          $display("FAIL c_overlap: got serial_clock=%0b during load, required 0", bus_c.serial_clock);
        end
      end
      if (pb === 1'b1 && bus_c.busy === 1'b0) busy_width_c = busy_run;
      busy_run = (bus_c.busy === 1'b1) ? busy_run + 1 : 0;
      ps = bus_c.serial_clock; pb = bus_c.busy; pdat = bus_c.serial_data;
    end
  endtask

  task automatic test_reset();
    logic [6:0]  obs_a;
    logic [10:0] obs_b;
    logic [6:0]  obs_c;
    reset_a = 1'b1; reset_bc = 1'b1;
    bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
    repeat (3) @(negedge clock);
    obs_a = {bus_a.cfg_addr, bus_a.serial_clock, bus_a.serial_data, bus_a.serial_load, bus_a.busy, bus_a.done};
    obs_b = {bus_b.cfg_addr, bus_b.serial_clock, bus_b.serial_data, bus_b.serial_load, bus_b.busy, bus_b.done};
    obs_c = {bus_c.cfg_addr, bus_c.serial_clock, bus_c.serial_data, bus_c.serial_load, bus_c.busy, bus_c.done};
    total++;
    if (obs_a !== 7'd0) begin bad++; $display("FAIL reset_a: got %b, required 0000000", obs_a); end
    total++;
    if (obs_b !== 11'd0) begin bad++; $display("FAIL reset_b: got %b, required all zero", obs_b); end
    total++;
    if (obs_c !== 7'd0) begin bad++; $display("FAIL reset_c: got %b, required 0000000", obs_c); end
    reset_a = 1'b0; reset_bc = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_stream();
    bit ok;
    int d0, l0;
    mem_a[0] = 4'hF; mem_a[1] = 4'h3; mem_a[2] = 4'hA; mem_a[3] = 4'h0;
    push_a();
    d0 = done_cnt_a; l0 = load_cnt_a;
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    total++;
    if (bus_a.busy !== 1'b1 || bus_a.cfg_addr !== 2'd2) begin
      bad++;
      $display("FAIL basic_start: got busy=%0b addr=%0d, required busy=1 addr=2", bus_a.busy, bus_a.cfg_addr);
    end
    wait_done(0, 100, ok);
    @(negedge clock);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: got no done, required done within 100 cycles"); end
    total++;
    if (busy_width_a != A_BUSY) begin bad++; $display("FAIL basic_busy: got %0d, required %0d", busy_width_a, A_BUSY); end
    total++;
    if (load_width_a != A_DIV || load_cnt_a != l0 + 1) begin
      bad++;
      $display("FAIL basic_load: got width %0d count %0d, required width %0d count %0d", load_width_a, load_cnt_a - l0, A_DIV, 1);
    end
    total++;
    if (done_cnt_a != d0 + 1) begin bad++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt_a - d0); end
    total++;
    if (exp_a.size() != 0) begin bad++; $display("FAIL basic_stream: got %0d bits missing, required 0", exp_a.size()); end
  endtask

  task automatic test_default_params();
    bit ok;
    int r0, errs;
    for (int i = 0; i < 64; i++) mem_b[i] = 13'(i);
    push_b();
    rec_b.delete();
    addr_log_b.delete();
    repeat ($urandom_range(1, 20)) @(negedge clock);
    r0 = rises_b;
    bus_b.start = 1'b1;
    @(negedge clock);
    bus_b.start = 1'b0;
    wait_done(1, 2200, ok);
    @(negedge clock);
    total++;
    if (!ok) begin bad++; $display("FAIL default_timeout: got no done, required done within 2200 cycles"); end
    total++;
    if (rises_b - r0 != 494) begin bad++; $display("FAIL default_rises: got %0d, required 494", rises_b - r0); end
    total++;
    if (busy_width_b != B_BUSY) begin bad++; $display("FAIL default_busy: got %0d, required %0d", busy_width_b, B_BUSY); end
    errs = 0;
    for (int i = 0; i < rec_b.size(); i++) if (rec_b[i] !== 13'(37 - i)) errs++;
    total++;
    if (rec_b.size() != 38 || errs != 0) begin
      bad++;
      $display("FAIL default_words: got %0d words with %0d wrong, required 38 words 37..0", rec_b.size(), errs);
    end
    errs = 0;
    for (int i = 0; i < addr_log_b.size(); i++) if (addr_log_b[i] !== 6'(37 - i)) errs++;
    total++;
    if (addr_log_b.size() != 38 || errs != 0) begin
      bad++;
      $display("FAIL default_addr: got %0d addresses with %0d wrong, required 37..0", addr_log_b.size(), errs);
    end
  endtask

  task automatic test_ignored_start();
    bit seen;
    int x0;
    mem_a[0] = 4'h9; mem_a[1] = 4'hC; mem_a[2] = 4'h5;
    push_a();
    x0 = xfer_cnt_a;
    seen = 1'b0;
    bus_a.start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus_a.done === 1'b1) begin
        bus_a.start = 1'b0;
        seen = 1'b1;
        break;
      end else if (bus_a.busy === 1'b1) begin
        bus_a.start = (i % 3 != 0);
      end else begin
        bus_a.start = 1'b0;
      end
    end
    repeat (10) @(negedge clock);
    total++;
    if (!seen) begin bad++; $display("FAIL ignored_timeout: got no done, required done within 100 cycles"); end
    total++;
    if (xfer_cnt_a != x0 + 1 || bus_a.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignored_count: got %0d transfers busy=%0b, required 1 busy=0", xfer_cnt_a - x0, bus_a.busy);
    end
    total++;
    if (busy_width_a != A_BUSY || exp_a.size() != 0) begin
      bad++;
      $display("FAIL ignored_stream: got busy %0d left %0d, required busy %0d left 0", busy_width_a, exp_a.size(), A_BUSY);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0, l0;
    logic [6:0] obs;
    mem_a[0] = 4'hC; mem_a[1] = 4'h9; mem_a[2] = 4'h6;
    push_a();
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus_a.cfg_addr === 2'd1) break;
    end
    total++;
    if (bus_a.cfg_addr !== 2'd1) begin bad++; $display("FAIL rstmid_reach: got addr %0d, required 1", bus_a.cfg_addr); end
    repeat (4) @(negedge clock);
    d0 = done_cnt_a; l0 = load_cnt_a;
    reset_a = 1'b1;
    @(negedge clock);
    obs = {bus_a.cfg_addr, bus_a.serial_clock, bus_a.serial_data, bus_a.serial_load, bus_a.busy, bus_a.done};
    total++;
    if (obs !== 7'd0) begin bad++; $display("FAIL rstmid_outputs: got %b, required 0000000", obs); end
    @(negedge clock);
    reset_a = 1'b0;
    exp_a.delete();
    repeat (10) @(negedge clock);
    total++;
    if (load_cnt_a != l0 || done_cnt_a != d0) begin
      bad++;
      $display("FAIL rstmid_abort: got %0d loads %0d dones, required 0 0", load_cnt_a - l0, done_cnt_a - d0);
    end
    push_a();
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    wait_done(0, 100, ok);
    @(negedge clock);
    total++;
    if (!ok || busy_width_a != A_BUSY || exp_a.size() != 0) begin
      bad++;
      $display("FAIL rstmid_rerun: got done=%0b busy %0d left %0d, required 1 %0d 0", ok, busy_width_a, exp_a.size(), A_BUSY);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0, x0;
    d0 = done_cnt_a; x0 = xfer_cnt_a;
    for (int p = 0; p < 3; p++) mem_a[p] = 4'(p * 3 + 1);
    push_a();
    bus_a.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(0, 100, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_timeout: transfer %0d got no done, required done", k); end
      if (k < 2) begin
        for (int p = 0; p < 3; p++) mem_a[p] = 4'((k + 1) * 5 + p * 3 + 2);
        push_a();
        @(negedge clock);
        total++;
        if (bus_a.busy !== 1'b1 || bus_a.cfg_addr !== 2'd2) begin
          bad++;
          $display("FAIL b2b_restart: got busy=%0b addr=%0d, required busy=1 addr=2", bus_a.busy, bus_a.cfg_addr);
        end
      end else begin
        bus_a.start = 1'b0;
      end
    end
    repeat (5) @(negedge clock);
    total++;
    if (done_cnt_a != d0 + 3 || xfer_cnt_a != x0 + 3 || exp_a.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d dones %0d transfers left %0d, required 3 3 0", done_cnt_a - d0, xfer_cnt_a - x0, exp_a.size());
    end
  endtask

  task automatic test_stability();
    bit ok;
    for (int p = 0; p < 4; p++) mem_c[p] = 5'($urandom_range(0, 31));
    push_c();
    bus_c.start = 1'b1;
    @(negedge clock);
    bus_c.start = 1'b0;
    wait_done(2, 200, ok);
    @(negedge clock);
    total++;
    if (!ok || busy_width_c != C_BUSY || exp_c.size() != 0) begin
      bad++;
      $display("FAIL stability_stream: got done=%0b busy %0d left %0d, required 1 %0d 0", ok, busy_width_c, exp_c.size(), C_BUSY);
    end
  endtask

  initial begin
    test_reset();
    fork
      monitor_a();
      monitor_b();
      monitor_c();
    join_none
    test_basic_stream();
    test_default_params();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_serial_loader.md
# gpio_serial_loader

Core-side transmitter for the user-pad configuration chain. It reads one configuration word per `mprj_io` pad from the housekeeping register bank, then shifts all words serially into the daisy-chained pad control blocks. When the last bit is in place, it pulses a load strobe so every control block latches its word in parallel. The pad controls it configures (`oeb`, `inp_dis`, `dm`, `vtrip_sel`, `slow_sel`, analog selects, ...) are what the padframe consumes.

## Interface
Parameters:
- `NUM_PADS`, default 38 (`MPRJ_IO_PADS`): pads in the chain.
- `CFG_BITS`, default 13: bits per pad configuration word.
- `CLK_DIV`, default 2, must be ≥1: `clock` cycles per `serial_clock` phase (low and high).

Ports:
- `clock`  in  1: single clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a full chain transfer; sampled only in IDLE.
- `cfg_addr`  out  $clog2(NUM_PADS): pad index being fetched.
- `cfg_word`  in  CFG_BITS: configuration word for `cfg_addr`; combinational, valid in the same cycle.
- `serial_clock`  out  1: chain shift clock; control blocks shift on its rising edge.
- `serial_data`  out  1: chain data, MSB first.
- `serial_load`  out  1: parallel latch strobe to all control blocks.
- `busy`  out  1: transfer in progress.
- `done`  out  1: one-cycle pulse at completion.

## Operation
States are IDLE, FETCH, SHIFT, LOAD.

- **IDLE**
  - Outputs: `serial_clock`=0, `serial_load`=0, `busy`=0.
  - `start`=1 → FETCH, with `cfg_addr`=NUM_PADS-1 and `busy`=1 from the next cycle.
- **FETCH** (exactly 1 cycle)
  - Latch `cfg_word` into the shift register.
  - Drive `serial_data` from the word MSB.
  - Bit counter cleared; → SHIFT.
- **SHIFT**: each bit occupies 2·CLK_DIV cycles.
  - `serial_clock` is low for the first CLK_DIV cycles, then high for CLK_DIV cycles.
  - `serial_data` is held stable for the whole bit period.
  - At the end of the high phase, `serial_clock` returns to 0 and the register shifts left, presenting the next bit.
  - After CFG_BITS bits:
    - if `cfg_addr`≠0: decrement `cfg_addr` → FETCH.
    - otherwise → LOAD.
- **LOAD**
  - `serial_load`=1 for CLK_DIV cycles with `serial_clock`=0.
  - Then → IDLE; `done`=1 for one cycle in that same cycle, with `busy`=0.

Pad order and stream content:
- Pad NUM_PADS-1 is shifted first, so that after the full stream pad 0's word sits nearest the transmitter.
- Stream = word[NUM_PADS-1] MSB…LSB, then word[NUM_PADS-2], …, then word[0].

Other rules:
- `serial_data` holds its last value in FETCH, LOAD and IDLE.
- `serial_data` is 0 after reset.
- `start` asserted while `busy` is ignored; it is not queued.
- All counters are sized to their maximum value, with no wrap.
  - Bit counter range: 0..CFG_BITS-1.
  - Divider counter range: 0..CLK_DIV-1.

## Timing
- Reset:
  - Takes effect on the next `clock` edge, including mid-transfer.
  - Sets state=IDLE, `cfg_addr`=0, `serial_clock`=0, `serial_data`=0, `serial_load`=0, `busy`=0, `done`=0.
  - No load strobe is issued for an aborted transfer.
- `start` high at edge N → `busy` high from cycle N+1.
- `busy` duration = NUM_PADS·(1 + 2·CLK_DIV·CFG_BITS) + CLK_DIV cycles.
  - With the defaults this is 38·53 + 2 = 2016 cycles.
- `done` is asserted in the first cycle after `busy` falls.
- Earliest accepted restart: `start` high in the `done` cycle, giving a new FETCH on the next cycle.
- All outputs are registered (no combinational path from inputs to outputs). Exception: `cfg_addr` → `cfg_word` is an external combinational path.
- `serial_data` setup to the rising edge of `serial_clock` is ≥ CLK_DIV cycles. Hold after the rising edge is ≥ CLK_DIV cycles.
- `serial_load` never overlaps a `serial_clock` high phase.

## Test plan
1. **Basic stream.** NUM_PADS=3, CFG_BITS=4, CLK_DIV=1; words pad2=0xA, pad1=0x3, pad0=0xF; pulse `start`.
   - Bits sampled on `serial_clock` rising edges = 1010 0011 1111.
   - `busy` high for 28 cycles, then `serial_load` high for 1 cycle, then `done` pulse.
2. **Default parameters.** Word = pad index, with a random `start` delay.
   - Exactly 494 `serial_clock` rising edges.
   - `busy` width 2016 cycles.
   - Recovered words equal 37…0 in order.
   - `cfg_addr` sequence is 37→0.
3. **Ignored start.** Assert `start` repeatedly during a transfer.
   - The transfer is unchanged.
   - No second transfer unless `start` is high in IDLE or in the `done` cycle.
4. **Reset mid-transfer.** Assert `reset` mid-SHIFT of pad 1.
   - The next cycle shows all outputs at reset values.
   - No `serial_load` and no `done`.
   - A following `start` produces a complete, correct stream.
5. **Data stability and strobe separation.** CLK_DIV=3, checked by an assertion monitor.
   - `serial_data` never changes while `serial_clock`=1 or within 3 cycles before its rise.
   - `serial_load` is never high together with `serial_clock`.
6. **Back-to-back transfers.** `start` is held high continuously.
   - Transfers run with exactly one IDLE/`done` cycle between them.
   - Each transfer delivers the `cfg_word` values current during its own FETCH cycles.
